octave_tone_gen: RTL and testbench
==================================

Name: octave_tone_gen

Overview:
- Parametrised successor to the keyboard octave scaler: takes a note's base half-period and a bank of octave switches, scales the period by a power of two, and generates the square-wave tone itself.
- Also outputs the matching scaled LED-rate value.
- Octave changes are applied glitch-free at a half-period boundary.
- Sits between the note decoder (base_period / base_led) and the audio PWM pin and LED blinker.

Parameters:
- W, 20, width of period, LED and counter datapaths.
- NUM_OCT, 8, number of octave switches.
- REF_OCT, 4, switch index giving unity scaling; the all-zero switch pattern also gives unity.
- DEB_CYC, 1000000, debounce stability count; used only with OCTAVE_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- oct_sw  in  NUM_OCT  octave switch bank (expected one-hot or zero)
- base_period  in  W  unscaled tone half-period in clk cycles
- base_led  in  W  unscaled LED update value
- tone_out  out  1  square-wave tone
- period_cur  out  W  half-period currently in use
- led_div  out  W  scaled LED value
- active_oct  out  $clog2(NUM_OCT+1)  selected octave index; NUM_OCT means zero/unity
- muted  out  1  high when no tone is produced
- update_ack  out  1  one-cycle pulse when a new period is loaded

Behaviour:
- Reset is synchronous, active-high, single clock domain.
- Reset values: tone_out=0, period_cur=0, led_div=0, active_oct=NUM_OCT, muted=1, update_ack=0, half-period counter=0, state=IDLE.
- Reset mid-operation: all of the above take effect on the next clock edge and any pending update is discarded.

Stage 1 (registered, 1-cycle latency from inputs to target):
- Decode oct_sw:
  - zero → unity;
  - exactly one bit i set → shift k = REF_OCT - i;
  - more than one bit set → invalid.
- Period target:
  - k>0: base_period << k, saturated to all-ones if any bit shifts out;
  - k<0: base_period >> -k;
  - k=0: base_period.
- LED target uses the opposite direction: base_led >> k for k>0, saturating << for k<0.
- Target is invalid if oct_sw is invalid or the period target is 0.

Stage 2 FSM (IDLE, RUN, PEND):
- IDLE: muted=1, tone_out=0.
  - On a valid target: load period_cur and led_div, clear the counter, pulse update_ack, go to RUN.
  - Latency from switch edge to first update_ack is 2 cycles.
- RUN: counter increments each cycle.
  - When counter == period_cur-1: toggle tone_out and clear the counter.
  - Target differs from period_cur (or led_div) → go to PEND.
  - Target invalid → go to IDLE immediately: tone_out=0, muted=1, period_cur=0.
- PEND: keep counting with the old period.
  - At the terminal count: toggle tone_out, load the new values, clear the counter, pulse update_ack, return to RUN.
  - Target changing again while in PEND: the latest target wins, with no extra ack.
  - Target invalid: go to IDLE immediately.
  - Target reverting to period_cur: return to RUN with no load and no ack.
- A terminal count and a target change in the same cycle: toggle with the old period, then enter PEND.
- period_cur=1 toggles every cycle.
- The counter never exceeds period_cur-1, so there is no wrap-around.
- active_oct updates with stage 1, i.e. 1 cycle after oct_sw.

Optional Feature:
- Macro: OCTAVE_DEBOUNCE_EN.
- Defined:
  - oct_sw passes through a 2-flop synchroniser and then a stability counter.
  - The debounced vector updates only after the synchronised value has been constant for DEB_CYC consecutive cycles.
  - Stage 1 uses the debounced vector, which adds 2+DEB_CYC cycles of latency.
  - The debounced vector resets to 0.
- Undefined:
  - oct_sw feeds stage 1 directly.
  - DEB_CYC is ignored.

Test Plan:
- W=20, reset then oct_sw=0, base_period=1000 → update_ack 2 cycles later; tone_out toggles every 1000 cycles; period_cur=1000, muted=0.
- oct_sw=8'b00000001, base_period=1000, base_led=32000 → period_cur=16000, led_div=2000, active_oct=0.
- Change oct_sw from bit4 to bit7 at counter=400 of a 1000-cycle half-period → old period completes 600 more cycles, then period_cur=125 with an update_ack pulse; no short or long half-period.
- oct_sw=8'b00000011 while running → muted=1 and tone_out=0 within 2 cycles, period_cur=0; restoring bit4 re-enters RUN.
- base_period=20'h10000, oct_sw bit0 → period_cur=20'hFFFFF (saturated); base_period=3, oct_sw bit7 (>>3 → 0) → muted.
- Assert reset during PEND → all outputs at reset values next cycle; after release, a valid target reloads from IDLE.

Source files
------------

// File: rtl/octave_tone_gen.sv
// octave_tone_gen: scales a note's base half-period / LED value by a power of
// two selected from a one-hot octave switch bank and generates the square-wave
// tone. Octave changes take effect only at a half-period boundary.
// Optional macro OCTAVE_DEBOUNCE_EN: synchronise and debounce oct_sw before use.
module octave_tone_gen #(
    parameter int W       = 20,
    parameter int NUM_OCT = 8,
    parameter int REF_OCT = 4,
    parameter int DEB_CYC = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_OCT-1:0]           oct_sw,
    input  logic [W-1:0]                 base_period,
    input  logic [W-1:0]                 base_led,
    output logic                         tone_out,
    output logic [W-1:0]                 period_cur,
    output logic [W-1:0]                 led_div,
    output logic [$clog2(NUM_OCT+1)-1:0] active_oct,
    output logic                         muted,
    output logic                         update_ack
);
    localparam int AW = $clog2(NUM_OCT+1);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    logic [NUM_OCT-1:0] oct_vec;

`ifdef OCTAVE_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYC+1);
    logic [NUM_OCT-1:0] sync1, sync2, cand, deb;
    logic [CW-1:0]      deb_cnt;

    // Two-flop synchroniser, then accept a value once it has held long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= oct_sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand    <= sync2;
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYC-1)) begin
                deb <= cand;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end
    assign oct_vec = deb;
`else
    logic deb_unused;
    assign deb_unused = (DEB_CYC == 0);
    assign oct_vec    = oct_sw;
`endif

    // Left shift that clamps to all-ones when any set bit would fall off the top.
    function automatic logic [W-1:0] shl_sat(input logic [W-1:0] v, input int sh);
        logic [2*W-1:0] wide;
        wide = {{W{1'b0}}, v} << sh;
        return (|wide[2*W-1:W]) ? {W{1'b1}} : wide[W-1:0];
    endfunction

    int             n_set, idx, k;
    logic [W-1:0]   p_d, l_d;
    logic           valid_d;
    logic [AW-1:0]  oct_d;
    logic [W-1:0]   tgt_period, tgt_led;
    logic           tgt_valid;

    // Stage 1 decode: switch pattern -> signed shift -> scaled period/LED targets.
    always_comb begin
        n_set = 0;
        idx   = 0;
        for (int i = 0; i < NUM_OCT; i++) begin
            if (oct_vec[i]) begin
                n_set = n_set + 1;
                idx   = i;
            end
        end
        k = (n_set == 1) ? (REF_OCT - idx) : 0;
        if (k > 0) begin
            p_d = shl_sat(base_period, k);
            l_d = base_led >> k;
        end else if (k < 0) begin
            p_d = base_period >> (-k);
            l_d = shl_sat(base_led, -k);
        end else begin
            p_d = base_period;
            l_d = base_led;
        end
        valid_d = (n_set <= 1) && (p_d != '0);
        oct_d   = (n_set == 1) ? AW'(idx) : AW'(NUM_OCT);
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_period <= '0;
            tgt_led    <= '0;
            tgt_valid  <= 1'b0;
            active_oct <= AW'(NUM_OCT);
        end else begin
            tgt_period <= p_d;
            tgt_led    <= l_d;
            tgt_valid  <= valid_d;
            active_oct <= oct_d;
        end
    end

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d, per_q, per_d, led_q, led_d;
    logic          tone_q, tone_d, ack_q, ack_d;
    logic          tc, differs;

    assign tc      = (cnt_q == per_q - W'(1));
    assign differs = (tgt_period != per_q) || (tgt_led != led_q);

    // Stage 2 next-state: tone counter, glitch-free reload at terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        per_d   = per_q;
        led_d   = led_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tone_d = 1'b0;
                cnt_d  = '0;
                if (tgt_valid) begin
                    per_d   = tgt_period;
                    led_d   = tgt_led;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, PEND: begin
                if (!tgt_valid) begin
                    state_d = IDLE;
                    tone_d  = 1'b0;
                    cnt_d   = '0;
                    per_d   = '0;
                    led_d   = '0;
                end else begin
                    if (tc) begin
                        tone_d = ~tone_q;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                    if (!differs) begin
                        state_d = RUN;
                    end else if (state_q == RUN) begin
                        // A change seen on a terminal count still toggles with
                        // the old period; the reload waits for the next boundary.
                        state_d = PEND;
                    end else if (tc) begin
                        per_d   = tgt_period;
                        led_d   = tgt_led;
                        ack_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 2 state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tone_q  <= 1'b0;
            per_q   <= '0;
            led_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            per_q   <= per_d;
            led_q   <= led_d;
            ack_q   <= ack_d;
        end
    end

    assign tone_out   = tone_q;
    assign period_cur = per_q;
    assign led_div    = led_q;
    assign update_ack = ack_q;
    assign muted      = (state_q == IDLE);
endmodule

// File: tb/tb_octave_tone_gen.sv
// Directed bench for octave_tone_gen (W=20, NUM_OCT=8, REF_OCT=4).
module tb_octave_tone_gen;
    localparam int W = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    oct_sw = '0;
    logic [W-1:0]  base_period = '0;
    logic [W-1:0]  base_led = '0;
    logic          tone_out;
    logic [W-1:0]  period_cur;
    logic [W-1:0]  led_div;
    logic [3:0]    active_oct;
    logic          muted;
    logic          update_ack;

    int n_vec = 0;
    int n_err = 0;

    octave_tone_gen #(.W(W), .NUM_OCT(8), .REF_OCT(4), .DEB_CYC(4)) dut (
        .clk(clk), .reset(reset), .oct_sw(oct_sw), .base_period(base_period),
        .base_led(base_led), .tone_out(tone_out), .period_cur(period_cur),
        .led_div(led_div), .active_oct(active_oct), .muted(muted),
        .update_ack(update_ack)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until tone_out changes, bounded by lim (returns lim on timeout).
    task automatic measure_half(input int lim, output int n);
        logic old;
        old = tone_out;
        n = 0;
        while (tone_out === old && n < lim) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; oct_sw = '0; base_period = '0; base_led = '0;
        step(2);
        n_vec++;
        if ({tone_out, period_cur, led_div, active_oct, muted, update_ack} !==
            {1'b0, 20'd0, 20'd0, 4'd8, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got t=%b p=%0d l=%0d o=%0d m=%b a=%b want 0 0 0 8 1 0",
                     tone_out, period_cur, led_div, active_oct, muted, update_ack);
        end
    endtask

    task automatic test_unity;
        int h;
        reset = 1'b0; oct_sw = '0; base_period = 20'd1000; base_led = 20'd500;
        step(1);
        n_vec++;
        if (update_ack !== 1'b0) begin n_err++; $display("FAIL unity_early_ack got %b want 0", update_ack); end
        step(1);
        n_vec++;
        if ({update_ack, period_cur, led_div, muted, active_oct, tone_out} !==
            {1'b1, 20'd1000, 20'd500, 1'b0, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL unity_load got a=%b p=%0d l=%0d m=%b o=%0d t=%b want 1 1000 500 0 8 0",
                     update_ack, period_cur, led_div, muted, active_oct, tone_out);
        end
        step(1);
        n_vec++;
        if (update_ack !== 1'b0) begin n_err++; $display("FAIL unity_ack_pulse got %b want 0", update_ack); end
        step(998);
        n_vec++;
        if (tone_out !== 1'b0) begin n_err++; $display("FAIL unity_first_toggle_early got %b want 0", tone_out); end
        step(1);
        n_vec++;
        if (tone_out !== 1'b1) begin n_err++; $display("FAIL unity_first_toggle got %b want 1", tone_out); end
        measure_half(2000, h);
        n_vec++;
        if (h !== 1000) begin n_err++; $display("FAIL unity_half_period got %0d want 1000", h); end
    endtask

    task automatic test_octave_down;
        reset = 1'b1; step(1);
        reset = 1'b0; oct_sw = 8'b0000_0001; base_period = 20'd1000; base_led = 20'd32000;
        step(1);
        n_vec++;
        if (active_oct !== 4'd0) begin n_err++; $display("FAIL down_active_oct got %0d want 0", active_oct); end
        step(1);
        n_vec++;
        if ({update_ack, period_cur, led_div} !== {1'b1, 20'd16000, 20'd2000}) begin
            n_err++;
            $display("FAIL down_load got a=%b p=%0d l=%0d want 1 16000 2000", update_ack, period_cur, led_div);
        end
    endtask

    task automatic test_pend;
        int h;
        reset = 1'b1; step(1);
        reset = 1'b0; oct_sw = 8'b0001_0000; base_period = 20'd1000; base_led = 20'd500;
        step(2);
        n_vec++;
        if ({update_ack, period_cur} !== {1'b1, 20'd1000}) begin
            n_err++; $display("FAIL pend_start got a=%b p=%0d want 1 1000", update_ack, period_cur);
        end
        step(400);
        oct_sw = 8'b1000_0000;
        step(599);
        n_vec++;
        if ({tone_out, period_cur, update_ack} !== {1'b0, 20'd1000, 1'b0}) begin
            n_err++; $display("FAIL pend_hold got t=%b p=%0d a=%b want 0 1000 0", tone_out, period_cur, update_ack);
        end
        step(1);
        n_vec++;
        if ({tone_out, period_cur, led_div, update_ack} !== {1'b1, 20'd125, 20'd4000, 1'b1}) begin
            n_err++;
            $display("FAIL pend_reload got t=%b p=%0d l=%0d a=%b want 1 125 4000 1",
                     tone_out, period_cur, led_div, update_ack);
        end
        measure_half(500, h);
        n_vec++;
        if (h !== 125) begin n_err++; $display("FAIL pend_new_half got %0d want 125", h); end
    endtask

    task automatic test_invalid;
        oct_sw = 8'b0000_0011;
        step(2);
        n_vec++;
        if ({muted, tone_out, period_cur} !== {1'b1, 1'b0, 20'd0}) begin
            n_err++; $display("FAIL invalid_mute got m=%b t=%b p=%0d want 1 0 0", muted, tone_out, period_cur);
        end
        oct_sw = 8'b0001_0000; base_period = 20'd1000;
        step(2);
        n_vec++;
        if ({update_ack, muted, period_cur} !== {1'b1, 1'b0, 20'd1000}) begin
            n_err++; $display("FAIL invalid_recover got a=%b m=%b p=%0d want 1 0 1000", update_ack, muted, period_cur);
        end
    endtask

    task automatic test_saturate;
        int h1, h2;
        reset = 1'b1; step(1);
        reset = 1'b0; oct_sw = 8'b0000_0001; base_period = 20'h10000; base_led = 20'd16;
        step(2);
        n_vec++;
        if ({update_ack, period_cur, led_div} !== {1'b1, 20'hFFFFF, 20'd1}) begin
            n_err++; $display("FAIL sat_period got a=%b p=%h l=%0d want 1 fffff 1", update_ack, period_cur, led_div);
        end
        oct_sw = 8'b1000_0000; base_period = 20'd3;
        step(1);
        n_vec++;
        if (active_oct !== 4'd7) begin n_err++; $display("FAIL zero_active_oct got %0d want 7", active_oct); end
        step(1);
        n_vec++;
        if ({muted, period_cur, tone_out} !== {1'b1, 20'd0, 1'b0}) begin
            n_err++; $display("FAIL zero_target_mute got m=%b p=%0d t=%b want 1 0 0", muted, period_cur, tone_out);
        end
        // Minimum period toggles every cycle.
        oct_sw = 8'b0001_0000; base_period = 20'd1;
        step(2);
        measure_half(10, h1);
        measure_half(10, h2);
        n_vec++;
        if (h1 !== 1 || h2 !== 1) begin n_err++; $display("FAIL period1_toggle got %0d,%0d want 1,1", h1, h2); end
    endtask

    task automatic test_reset_pend;
        oct_sw = 8'b0001_0000; base_period = 20'd1000; base_led = 20'd500;
        step(12);
        oct_sw = 8'b1000_0000;
        step(3);
        reset = 1'b1;
        step(1);
        n_vec++;
        if ({tone_out, period_cur, led_div, active_oct, muted, update_ack} !==
            {1'b0, 20'd0, 20'd0, 4'd8, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_in_pend got t=%b p=%0d l=%0d o=%0d m=%b a=%b want 0 0 0 8 1 0",
                     tone_out, period_cur, led_div, active_oct, muted, update_ack);
        end
        reset = 1'b0;
        step(2);
        n_vec++;
        if ({update_ack, period_cur, led_div, muted} !== {1'b1, 20'd125, 20'd4000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_reload got a=%b p=%0d l=%0d m=%b want 1 125 4000 0",
                     update_ack, period_cur, led_div, muted);
        end
    endtask

    initial begin
        test_reset;
        test_unity;
        test_octave_down;
        test_pend;
        test_invalid;
        test_saturate;
        test_reset_pend;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
